// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the MCPU datapath: one state per cycle,
// decoding IR opcode/funct into write enables, mux selects and ALU commands.
module mcpu_ctrl_fsm #(
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1,
  parameter logic [2:0] ALU_XOR = 3'd2,
  parameter logic [2:0] ALU_SLT = 3'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       a_we,
  output logic       b_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       memin,
  output logic       regin,
  output logic       dst,
  output logic       jal,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JALWB  = 4'd13,
    S_JR     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t state_q, state_d;

  logic       pc_we_c, ir_we_c, a_we_c, b_we_c, mem_we_c, reg_we_c;
  logic       memin_c, regin_c, dst_c, jal_c, done_c, illegal_c;
  logic [1:0] alusrca_c, alusrcb_c, pcsrc_c;
  logic [2:0] aluop_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    a_we_c    = 1'b0;
    b_we_c    = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    memin_c   = 1'b0;
    regin_c   = 1'b0;
    dst_c     = 1'b0;
    jal_c     = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    alusrca_c = 2'd0;
    alusrcb_c = 2'd0;
    pcsrc_c   = 2'd0;
    aluop_c   = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_we_c   = 1'b1;
          pc_we_c   = 1'b1;
          alusrcb_c = 2'd3;
          pcsrc_c   = 2'd2;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU computes the branch target here so BRANCH can use pcsrc=3
        a_we_c = 1'b1;
        b_we_c = 1'b1;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MADDR;
          OP_ADDI, OP_XORI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) begin
              state_d = S_REXEC;
            end else if (funct == FN_JR) begin
              state_d = S_JR;
            end else begin
              illegal_c = 1'b1;
              done_c    = 1'b1;
            end
          end
          default: begin
            illegal_c = 1'b1;
            done_c    = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        alusrca_c = 2'd1;
        alusrcb_c = 2'd1;
        state_d   = (opcode == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        memin_c = 1'b1;
        state_d = S_MWB;
      end
      S_MWB: begin
        reg_we_c = 1'b1;
        dst_c    = 1'b1;
        done_c   = 1'b1;
      end
      S_MWR: begin
        memin_c  = 1'b1;
        mem_we_c = 1'b1;
        done_c   = 1'b1;
      end
      S_REXEC: begin
        alusrca_c = 2'd1;
        alusrcb_c = 2'd2;
        case (funct)
          FN_SUB:  aluop_c = ALU_SUB;
          FN_SLT:  aluop_c = ALU_SLT;
          default: aluop_c = ALU_ADD;
        endcase
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_we_c = 1'b1;
        regin_c  = 1'b1;
        done_c   = 1'b1;
      end
      S_IEXEC: begin
        alusrca_c = 2'd1;
        alusrcb_c = 2'd1;
        aluop_c   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_we_c = 1'b1;
        regin_c  = 1'b1;
        dst_c    = 1'b1;
        done_c   = 1'b1;
      end
      S_BRANCH: begin
        // the only Mealy output: taken decision comes straight from the ALU flag
        alusrca_c = 2'd1;
        alusrcb_c = 2'd2;
        aluop_c   = ALU_SUB;
        pcsrc_c   = 2'd3;
        pc_we_c   = (opcode == OP_BNE) ? ~zero : zero;
        done_c    = 1'b1;
      end
      S_JUMP: begin
        pcsrc_c = 2'd1;
        pc_we_c = 1'b1;
        done_c  = 1'b1;
      end
      S_JAL: begin
        // PC already holds addr+4, so PC+4 here is the addr+8 link value
        alusrcb_c = 2'd3;
        pcsrc_c   = 2'd1;
        pc_we_c   = 1'b1;
        state_d   = S_JALWB;
      end
      S_JALWB: begin
        reg_we_c = 1'b1;
        regin_c  = 1'b1;
        jal_c    = 1'b1;
        done_c   = 1'b1;
      end
      S_JR: begin
        alusrca_c = 2'd1;
        alusrcb_c = 2'd2;
        pcsrc_c   = 2'd2;
        pc_we_c   = 1'b1;
        done_c    = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Asynchronous reset must silence every control immediately, not at the next edge
  always_comb begin
    pc_we      = reset & pc_we_c;
    ir_we      = reset & ir_we_c;
    a_we       = reset & a_we_c;
    b_we       = reset & b_we_c;
    mem_we     = reset & mem_we_c;
    reg_we     = reset & reg_we_c;
    memin      = reset & memin_c;
    regin      = reset & regin_c;
    dst        = reset & dst_c;
    jal        = reset & jal_c;
    instr_done = reset & done_c;
    illegal    = reset & illegal_c;
    alusrca    = reset ? alusrca_c : 2'd0;
    alusrcb    = reset ? alusrcb_c : 2'd0;
    aluop      = reset ? aluop_c   : 3'd0;
    pcsrc      = reset ? pcsrc_c   : 2'd0;
    state      = reset ? state_q   : 4'd0;
  end

endmodule

// File: doc/mcpu_ctrl_fsm.md
Name: mcpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MCPU datapath (PC, IR, A/B, ALU-out, MDR registers; shared instruction/data memory; regfile).
- Decodes the IR opcode and funct fields and drives every write enable, mux select and ALU command, one state per cycle.
- Instructions covered: LW, SW, ADDI, XORI, ADD, SUB, SLT, JR, BEQ, BNE, J, JAL.
- Moore outputs, except `pc_we` in BRANCH, which depends on the `zero` input.

Parameters:
- ALU_ADD, 3'd0, ALU command for add
- ALU_SUB, 3'd1, ALU command for subtract
- ALU_XOR, 3'd2, ALU command for xor
- ALU_SLT, 3'd3, ALU command for set-less-than

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  start/continue; sampled only in FETCH
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational
- pc_we, ir_we, a_we, b_we, mem_we, reg_we  out  1 each  write enables
- memin  out  1  memory address select: 0=PC, 1=ALU register
- regin  out  1  regfile write data: 0=MDR, 1=ALU register
- dst  out  1  write register select: 0=rd, 1=rt
- jal  out  1  force write register to 31
- alusrca  out  2  0=PC, 1=A, 2=branch register, 3=zero
- alusrcb  out  2  0=imm<<2, 1=sign-extended imm, 2=B, 3=constant 4
- aluop  out  3  ALU command
- pcsrc  out  2  0=branch mux, 1=jump concat, 2=ALU out, 3=ALU register
- state  out  4  current state code, for debug
- instr_done  out  1  high in the final state of each instruction
- illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset (reset low, asynchronous): state becomes FETCH (0). All outputs are forced to 0 while reset is low. First active edge after release executes FETCH.
- Every control not listed for a state is 0 in that state.
- 0 FETCH:
  - If run=1: memin=0, ir_we=1, alusrca=0, alusrcb=3, aluop=ADD, pcsrc=2, pc_we=1; next DECODE.
  - If run=0: all enables 0; stay in FETCH.
- 1 DECODE: a_we=b_we=1, alusrca=0, alusrcb=0, aluop=ADD (branch target into ALU register). Next state by opcode:
  - 0x23 or 0x2B -> MADDR
  - 0x00 with funct 0x20, 0x22 or 0x2A -> REXEC
  - 0x00 with funct 0x08 -> JR
  - 0x08 or 0x0E -> IEXEC
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> FETCH, with illegal=1 and instr_done=1
- 2 MADDR: alusrca=1, alusrcb=1, aluop=ADD; next MRD if LW, else MWR.
- 3 MRD: memin=1 (MDR loads every cycle); next MWB.
- 4 MWB: reg_we=1, regin=0, dst=1, instr_done=1; next FETCH.
- 5 MWR: memin=1, mem_we=1, instr_done=1; next FETCH.
- 6 REXEC: alusrca=1, alusrcb=2; aluop = ADD for funct 0x20, SUB for 0x22, SLT for 0x2A; next RWB.
- 7 RWB: reg_we=1, regin=1, dst=0, instr_done=1; next FETCH.
- 8 IEXEC: alusrca=1, alusrcb=1; aluop = ADD for 0x08, XOR for 0x0E; next IWB.
- 9 IWB: reg_we=1, regin=1, dst=1, instr_done=1; next FETCH.
- 10 BRANCH: alusrca=1, alusrcb=2, aluop=SUB, pcsrc=3, instr_done=1; next FETCH.
  - pc_we = zero for BEQ, ~zero for BNE.
- 11 JUMP: pcsrc=1, pc_we=1, instr_done=1; next FETCH.
- 12 JAL: alusrca=0, alusrcb=3, aluop=ADD, pcsrc=1, pc_we=1; next JALWB.
  - Link value is JAL address + 8, since PC already holds address + 4.
- 13 JALWB: reg_we=1, regin=1, jal=1, instr_done=1; next FETCH.
- 14 JR: alusrca=1, alusrcb=2 (rt = $0), aluop=ADD, pcsrc=2, pc_we=1, instr_done=1; next FETCH.
- Codes 15 and unused: next FETCH, illegal=1, no enables.
- Cycle counts: LW 5; SW, R-type, I-type, JAL 4; BRANCH, J, JR 3; illegal 2.
- opcode and funct are sampled in DECODE and in every later state of the instruction; the IR is stable because ir_we is asserted only in FETCH.
- Reset asserted mid-instruction aborts the instruction immediately; no further enable pulses occur.
- run=0 does not interrupt an instruction in flight; it is checked only in FETCH.

Test Plan:
- Reset low for 3 cycles, then high with run=1 -> state=0 and all outputs 0 during reset; first cycle shows ir_we=pc_we=1, alusrcb=3, pcsrc=2.
- LW (opcode 0x23) -> states 0,1,2,3,4; mem_we never 1; final cycle reg_we=1, regin=0, dst=1, instr_done=1.
- BEQ with zero=1, then BEQ with zero=0, then BNE with zero=0 -> BRANCH pc_we = 1, 0, 1 respectively; pcsrc=3 each time.
- JAL (opcode 0x03) -> states 0,1,12,13; in state 12 pc_we=1, pcsrc=1; in state 13 reg_we=1, jal=1, regin=1.
- R-type with funct 0x2A -> aluop=3 in REXEC; opcode 0x3F -> illegal pulses for 1 cycle in DECODE, then back to FETCH.
- run=0 held for 4 cycles -> stays in FETCH, all enables 0. Reset asserted during MRD -> state=0 within the same cycle, and reg_we never fires for that LW.
